// File: rtl/grf_mp_scoreboard.sv
// grf_mp_scoreboard
// Multi-port general register file with two write ports, same-cycle
// write->read bypass, a per-register pending scoreboard for the hazard unit,
// and a committed-write counter. Entry 0 reads as zero and is never written.

module grf_mp_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  // W0: memory/ALU writeback
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  // W1: mult/div or late writeback, wins a same-address collision with W0
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  // Read ports, flattened; port k occupies slice k
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        busy,
  // Issue of an instruction that will later write issue_addr
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [(2**ADDR_W)-1:0]   pend_vec,
  output logic [31:0]              wr_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [31:0]       wr_count_q, wr_count_d;

  // Accepted writes: address 0 is discarded, and W0 is dropped when W1
  // targets the same register in the same cycle.
  logic w1_ok, w0_ok;

  // Qualify the two write ports against address 0 and against each other
  always_comb begin
    w1_ok = we1 && (wa1 != '0);
    w0_ok = we0 && (wa0 != '0) && !(w1_ok && (wa1 == wa0));
  end

  // Next array contents: W1 is applied after W0 so it wins a collision
  always_comb begin
    // NOTE: every always_comb output starts from a full default so no path
    // leaves it unassigned; blocking '=' is correct here because later
    // statements deliberately override earlier ones within the same pass.
    mem_d = mem_q;
    if (w0_ok) mem_d[wa0] = wd0;
    if (w1_ok) mem_d[wa1] = wd1;
    mem_d[0] = '0;
  end

  // Next scoreboard: clears first, then the issue set, so a new producer
  // issued in the same cycle as an older one retires keeps the bit set
  always_comb begin
    pend_d = pend_q;
    if (we0)      pend_d[wa0]        = 1'b0;
    if (we1)      pend_d[wa1]        = 1'b0;
    if (issue_en) pend_d[issue_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Next write count: add the number of accepted writes, wrapping freely
  always_comb begin
    wr_count_d = wr_count_q + {31'd0, w0_ok} + {31'd0, w1_ok};
  end

  // State update; synchronous reset clears everything and discards the
  // writes and issues presented in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array itself is reset because software relies on
      // every register reading zero after reset; this costs a reset on each
      // flop, so it cannot be mapped to a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q     <= '0;
      wr_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // values from before the edge, independent of statement order.
      mem_q      <= mem_d;
      pend_q     <= pend_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign pend_vec = pend_q;
  assign wr_count = wr_count_q;

  // Read ports: combinational, bypassing same-cycle writes (W1 over W0),
  // zero for address 0, and no bypass while reset is asserted
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic              nz;
    logic              hit0;
    logic              hit1;

    assign ra_k = ra[k*ADDR_W +: ADDR_W];
    assign nz   = (ra_k != '0);
    assign hit1 = !reset && we1 && (wa1 == ra_k) && nz;
    assign hit0 = !reset && we0 && (wa0 == ra_k) && nz;

    assign rd[k*DATA_W +: DATA_W] = !nz  ? '0  :
                                    hit1 ? wd1 :
                                    hit0 ? wd0 :
                                           mem_q[ra_k];

    // A pending operand stops being a hazard the cycle its value is bypassed
    assign busy[k] = nz && pend_q[ra_k] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_grf_mp_scoreboard.sv
// tb_grf_mp_scoreboard
// Directed table-driven bench for grf_mp_scoreboard (default parameters).
// Each vector is driven after a falling edge; read data and busy are checked
// before the rising edge, pend_vec and wr_count just after it.

module tb_grf_mp_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     we0, we1;
  logic [ADDR_W-1:0]        wa0, wa1;
  logic [DATA_W-1:0]        wd0, wd1;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        busy;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic [(2**ADDR_W)-1:0]   pend_vec;
  logic [31:0]              wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grf_mp_scoreboard #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we0       (we0),
    .wa0       (wa0),
    .wd0       (wd0),
    .we1       (we1),
    .wa1       (wa1),
    .wd1       (wd1),
    .ra        (ra),
    .rd        (rd),
    .busy      (busy),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .pend_vec  (pend_vec),
    .wr_count  (wr_count)
  );

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss;
    logic [4:0]  ia;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic [31:0] e_pend;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst,
                     input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                     input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                     input logic [4:0] r0, input logic [4:0] r1,
                     input logic is, input logic [4:0] ia,
                     input logic [31:0] x0, input logic [31:0] x1, input logic [1:0] xb,
                     input logic [31:0] xp, input logic [31:0] xc);
    vec_t v;
    v.rst = rst; v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1; v.ra0 = r0; v.ra1 = r1;
    v.iss = is; v.ia = ia; v.e_rd0 = x0; v.e_rd1 = x1; v.e_busy = xb;
    v.e_pend = xp; v.e_cnt = xc;
    tv.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic w0, input logic [4:0] a0,
                       input logic [31:0] d0, input logic w1, input logic [4:0] a1,
                       input logic [31:0] d1, input logic [4:0] r0, input logic [4:0] r1,
                       input logic is, input logic [4:0] ia);
    reset = rst; we0 = w0; wa0 = a0; wd0 = d0; we1 = w1; wa1 = a1; wd1 = d1;
    ra = {r1, r0}; issue_en = is; issue_addr = ia;
  endtask

  initial begin
    //   rst we0 wa0 wd0           we1 wa1 wd1           ra0 ra1 iss ia  rd0           rd1           busy   pend          cnt
    // Write 5, visible through bypass then from the array
    add(0, 1, 5, 32'h1234,       0, 0, 0,              5,  0,  0, 0,  32'h1234,     32'h0,        2'b00, 32'h0,        1);
    add(0, 0, 0, 0,              0, 0, 0,              5,  0,  0, 0,  32'h1234,     32'h0,        2'b00, 32'h0,        1);
    // Same-address collision: W1 wins, counts once
    add(0, 1, 3, 32'hA,          1, 3, 32'hB,          3,  5,  0, 0,  32'hB,        32'h1234,     2'b00, 32'h0,        2);
    add(0, 0, 0, 0,              0, 0, 0,              3,  0,  0, 0,  32'hB,        32'h0,        2'b00, 32'h0,        2);
    // Zero register: write ignored, not counted
    add(0, 1, 0, 32'hFFFF_FFFF,  0, 0, 0,              0,  3,  0, 0,  32'h0,        32'hB,        2'b00, 32'h0,        2);
    add(0, 0, 0, 0,              0, 0, 0,              0,  0,  0, 0,  32'h0,        32'h0,        2'b00, 32'h0,        2);
    // Scoreboard on reg 7, cleared by W1 with bypass
    add(0, 0, 0, 0,              0, 0, 0,              0,  7,  1, 7,  32'h0,        32'h0,        2'b00, 32'h80,       2);
    add(0, 0, 0, 0,              0, 0, 0,              0,  7,  0, 0,  32'h0,        32'h0,        2'b10, 32'h80,       2);
    add(0, 0, 0, 0,              1, 7, 32'h77,         0,  7,  0, 0,  32'h0,        32'h77,       2'b00, 32'h0,        3);
    add(0, 0, 0, 0,              0, 0, 0,              0,  7,  0, 0,  32'h0,        32'h77,       2'b00, 32'h0,        3);
    // Two writes to different registers count twice
    add(0, 1, 10, 32'hAA,        1, 11, 32'hBB,        10, 11, 0, 0,  32'hAA,       32'hBB,       2'b00, 32'h0,        5);
    // Set-wins on reg 9
    add(0, 0, 0, 0,              0, 0, 0,              0,  0,  1, 9,  32'h0,        32'h0,        2'b00, 32'h200,      5);
    add(0, 1, 9, 32'h99,         0, 0, 0,              9,  0,  1, 9,  32'h99,       32'h0,        2'b00, 32'h200,      6);
    add(0, 0, 0, 0,              0, 0, 0,              9,  0,  0, 0,  32'h99,       32'h0,        2'b01, 32'h200,      6);
    // Issue to reg 0 never sets a bit
    add(0, 0, 0, 0,              0, 0, 0,              0,  9,  1, 0,  32'h0,        32'h99,       2'b10, 32'h200,      6);
    // W0 clears reg 9
    add(0, 1, 9, 32'h9A,         0, 0, 0,              9,  7,  0, 0,  32'h9A,       32'h77,       2'b00, 32'h0,        7);
    add(0, 0, 0, 0,              0, 0, 0,              0,  0,  1, 12, 32'h0,        32'h0,        2'b00, 32'h1000,     7);
    // Mid-operation reset: no bypass, writes/issue discarded
    add(1, 1, 4, 32'h44,         1, 9, 32'h55,         4,  9,  1, 4,  32'h0,        32'h9A,       2'b00, 32'h0,        0);
    add(0, 0, 0, 0,              0, 0, 0,              9,  4,  0, 0,  32'h0,        32'h0,        2'b00, 32'h0,        0);
    add(0, 0, 0, 0,              0, 0, 0,              5,  7,  0, 0,  32'h0,        32'h0,        2'b00, 32'h0,        0);

    // Initial reset held for two edges
    drive(1, 0, 0, 0, 0, 0, 0, 5, 3, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset rd0", rd[31:0], 32'h0);
    check("reset rd1", rd[63:32], 32'h0);
    check("reset busy", {30'd0, busy}, 32'h0);
    check("reset pend", pend_vec, 32'h0);
    check("reset cnt", wr_count, 32'h0);

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].we0, tv[i].wa0, tv[i].wd0, tv[i].we1, tv[i].wa1,
            tv[i].wd1, tv[i].ra0, tv[i].ra1, tv[i].iss, tv[i].ia);
      #1;
      check($sformatf("v%0d rd0", i), rd[31:0], tv[i].e_rd0);
      check($sformatf("v%0d rd1", i), rd[63:32], tv[i].e_rd1);
      check($sformatf("v%0d busy", i), {30'd0, busy}, {30'd0, tv[i].e_busy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d pend", i), pend_vec, tv[i].e_pend);
      check($sformatf("v%0d cnt", i), wr_count, tv[i].e_cnt);
    end

    // Hand sequence: pipeline of issue then late writeback while a new
    // issue targets the next register
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 20, 21, 1, 20);
    @(negedge clk);
    drive(0, 1, 6, 32'h66, 1, 20, 32'h2020, 20, 6, 1, 21);
    #1;
    check("seq bypass rd0", rd[31:0], 32'h2020);
    check("seq bypass rd1", rd[63:32], 32'h66);
    check("seq busy", {30'd0, busy}, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 21, 20, 0, 0);
    #1;
    check("seq pend", pend_vec, 32'h0020_0000);
    check("seq cnt", wr_count, 32'd2);
    check("seq busy21", {30'd0, busy}, 32'h1);
    check("seq rd1", rd[63:32], 32'h2020);

    // Hand sequence: reset held two edges with writes and issues present
    @(negedge clk);
    drive(1, 1, 6, 32'hDEAD, 1, 8, 32'hBEEF, 6, 8, 1, 6);
    #1;
    check("rst hold rd0", rd[31:0], 32'h66);
    check("rst hold rd1", rd[63:32], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 6, 20, 0, 0);
    #1;
    check("post rst rd0", rd[31:0], 32'h0);
    check("post rst rd1", rd[63:32], 32'h0);
    check("post rst pend", pend_vec, 32'h0);
    check("post rst cnt", wr_count, 32'h0);
    check("post rst busy", {30'd0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
